display_ctrl: RTL and testbench



---
 rtl/display_ctrl.sv | 171 +++++++++++++++++
 tb/tb_display_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/display_ctrl.sv
// Memory-mapped display controller: DSR/DDR registers, character FIFO and print-strobe drain FSM.
// Optional display-ready interrupt (IE bit, irq output) is built only when DISPLAY_INT_EN is defined.
module display_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int PRINT_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    output logic [15:0] out_data,
    output logic        print,
    output logic        irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [15:0]   DSR_ADDR   = 16'hFE04;
    localparam logic [15:0]   DDR_ADDR   = 16'hFE06;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]    GAP        = 4'(PRINT_GAP);

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [3:0]    hold_cnt;
    logic          ovf;
    logic          ie;

    logic dsr_sel;
    logic ddr_sel;
    logic full;
    logic empty;
    logic ready;
    logic push;
    logic pop;
    logic ovf_set;
    logic ovf_clear;

    assign dsr_sel   = (addr == DSR_ADDR);
    assign ddr_sel   = (addr == DDR_ADDR);
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign ready     = ~full;
    assign push      = we & ddr_sel & ~full;
    assign ovf_set   = we & ddr_sel & full;
    assign pop       = (state == IDLE) & ~empty;
    assign ovf_clear = (re & dsr_sel) | (we & dsr_sel & wdata[0]);

    always_comb begin
        rdata = 16'h0000;
        if (re && dsr_sel) begin
            rdata = {ready, ie, 13'b0, ovf};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Overflow set wins over any clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clear) begin
            ovf <= 1'b0;
        end
    end

`ifdef DISPLAY_INT_EN
    logic ie_q;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (we && dsr_sel) begin
                ie_q <= wdata[14];
            end
            irq_q <= ie_q & ready;
        end
    end

    assign ie  = ie_q;
    assign irq = irq_q;
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    // print is registered so it rises exactly one cycle after out_data settles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            out_data <= 16'h0000;
            print    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    print <= 1'b0;
                    if (!empty) begin
                        out_data <= mem[rd_ptr];
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    print <= 1'b1;
                    state <= STROBE;
                end
                STROBE: begin
                    print    <= 1'b0;
                    hold_cnt <= GAP;
                    state    <= HOLD;
                end
                HOLD: begin
                    print <= 1'b0;
                    if (hold_cnt <= 4'd1) begin
                        hold_cnt <= 4'd0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    print <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_ctrl.sv
// Self-checking bench for display_ctrl: directed scenarios plus random CPU traffic against a
// queue-and-timestamp reference model of the display protocol.
module tb_display_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int PRINT_GAP  = 2;
    localparam logic [15:0] DSR = 16'hFE04;
    localparam logic [15:0] DDR = 16'hFE06;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] rdata;
    logic [15:0] out_data;
    logic        print;
    logic        irq;

    display_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .PRINT_GAP(PRINT_GAP)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .out_data(out_data), .print(print), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending characters, last pop time and earliest next pop time.
    logic [15:0] q[$];
    int          cycle    = 0;
    int          next_ok  = 0;
    int          last_pop = -10;
    logic [15:0] out_m    = 16'h0000;
    logic        ovf_m    = 1'b0;
    logic        ie_m     = 1'b0;
    logic        irq_m    = 1'b0;
    logic        print_m  = 1'b0;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cycle, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [15:0] a, input logic [15:0] d,
                                 input logic w, input logic rd);
        logic        full_m;
        logic [15:0] exp_rdata;
        @(negedge clk);
        rst = r; addr = a; wdata = d; we = w; re = rd;
        #1;
        full_m    = (q.size() == FIFO_DEPTH);
        exp_rdata = (rd && a == DSR) ? {~full_m, ie_m, 13'b0, ovf_m} : 16'h0000;
        checkOutput("rdata", rdata, exp_rdata);
        @(posedge clk);
        cycle++;
        if (r) begin
            q.delete();
            next_ok  = 0;
            last_pop = -10;
            out_m    = 16'h0000;
            ovf_m    = 1'b0;
            ie_m     = 1'b0;
            irq_m    = 1'b0;
        end else begin
`ifdef DISPLAY_INT_EN
            irq_m = ie_m & ~full_m;
            if (w && a == DSR) ie_m = d[14];
`else
            irq_m = 1'b0;
`endif
            if (q.size() > 0 && cycle >= next_ok) begin
                out_m    = q.pop_front();
                last_pop = cycle;
                next_ok  = cycle + PRINT_GAP + 3;
            end
            if (w && a == DDR && !full_m) q.push_back(d);
            if (w && a == DDR && full_m) ovf_m = 1'b1;
            else if ((rd && a == DSR) || (w && a == DSR && d[0])) ovf_m = 1'b0;
        end
        print_m = (last_pop == cycle - 1);
        #1;
        checkOutput("out_data", out_data, out_m);
        checkOutput("print", {15'b0, print}, {15'b0, print_m});
        checkOutput("irq", {15'b0, irq}, {15'b0, irq_m});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, DSR, 16'h0000, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] a;
        int          sel;
        rst = 1'b1; addr = 16'h0000; wdata = 16'h0000; we = 1'b0; re = 1'b0;
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, DSR, 16'h0000, 1'b0, 1'b1);

        // Single character latency.
        applyStimulus(1'b0, DDR, 16'd42, 1'b1, 1'b0);
        idle(8);

        // Back-to-back characters.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, DDR, 16'(i), 1'b1, 1'b0);
        idle(25);

        // Overflow: six consecutive writes, last one 99 dropped, then DSR reads.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, DDR, 16'(10 + i), 1'b1, 1'b0);
        applyStimulus(1'b0, DDR, 16'd99, 1'b1, 1'b0);
        applyStimulus(1'b0, DSR, 16'h0000, 1'b0, 1'b1);
        idle(30);

        // Reset during strobe with entries queued.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, DDR, 16'(200 + i), 1'b1, 1'b0);
        for (int i = 0; i < 20 && !print_m; i++) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checkOutput("strobe_reached", {15'b0, print_m}, 16'h0001);
        applyStimulus(1'b1, DDR, 16'd77, 1'b1, 1'b0);
        idle(20);

        // Interrupt enable, then fill.
        applyStimulus(1'b0, DSR, 16'h4000, 1'b1, 1'b0);
        idle(3);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, DDR, 16'(300 + i), 1'b1, 1'b0);
        idle(30);

        // Random CPU traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      a = DDR;
            else if (sel < 8) a = DSR;
            else              a = 16'($urandom);
            applyStimulus(($urandom_range(0, 63) == 0), a, 16'($urandom),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
